// File: rtl/axis_packetizer.sv
// axis_packetizer: frames a raw AXI4-Stream into packets by generating TLAST.
// One beat is held back so TLAST can be attached on size, idle timeout or flush.
module axis_packetizer #(
  parameter int TDATA_WIDTH = 128,
  parameter int PKT_LEN     = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
  input  logic                     S_AXIS_TVALID,
  output logic                     S_AXIS_TREADY,
  input  logic                     flush,
  output logic [TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                     M_AXIS_TLAST,
  output logic                     M_AXIS_TVALID,
  input  logic                     M_AXIS_TREADY,
  output logic [31:0]              pkt_count,
  output logic [31:0]              short_pkt_count
);

  localparam int KW = TDATA_WIDTH / 8;
  localparam int CW = $clog2(PKT_LEN) + 1;
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PKT_LEN - 1);
  localparam logic [IW-1:0] IDLE_MAX =
    IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic                   h_valid_q, h_valid_d;
  logic [TDATA_WIDTH-1:0] h_data_q, h_data_d;
  logic [KW-1:0]          h_keep_q, h_keep_d;
  logic                   h_last_q, h_last_d;
  logic                   h_short_q, h_short_d;
  logic                   o_valid_q, o_valid_d;
  logic [TDATA_WIDTH-1:0] o_data_q, o_data_d;
  logic [KW-1:0]          o_keep_q, o_keep_d;
  logic                   o_last_q, o_last_d;
  logic                   o_short_q, o_short_d;
  logic [CW-1:0]          beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]          idle_cnt_q, idle_cnt_d;
  logic [31:0]            pkt_cnt_q, pkt_cnt_d;
  logic [31:0]            short_cnt_q, short_cnt_d;

  logic o_free, s_ready, accept, move;
  logic h_open, timed_out, seal;
  logic new_last, new_short, m_hs;

  always_comb begin
    o_free    = !o_valid_q || M_AXIS_TREADY;
    s_ready   = aresetn && (!h_valid_q || o_free);
    accept    = S_AXIS_TVALID && s_ready;
    move      = o_free && h_valid_q && (h_last_q || accept);
    h_open    = h_valid_q && !h_last_q;
    timed_out = (TIMEOUT != 0) && (idle_cnt_q == IDLE_MAX);
    seal      = h_open && !accept && (flush || timed_out);
    new_last  = (beat_cnt_q == LAST_CNT) || flush;
    new_short = flush && (beat_cnt_q < LAST_CNT);
    m_hs      = o_valid_q && M_AXIS_TREADY;

    h_valid_d   = h_valid_q;
    h_data_d    = h_data_q;
    h_keep_d    = h_keep_q;
    h_last_d    = h_last_q;
    h_short_d   = h_short_q;
    beat_cnt_d  = beat_cnt_q;
    o_valid_d   = o_valid_q;
    o_data_d    = o_data_q;
    o_keep_d    = o_keep_q;
    o_last_d    = o_last_q;
    o_short_d   = o_short_q;
    pkt_cnt_d   = pkt_cnt_q;
    short_cnt_d = short_cnt_q;

    if (accept) begin
      h_valid_d  = 1'b1;
      h_data_d   = S_AXIS_TDATA;
      h_keep_d   = S_AXIS_TKEEP;
      h_last_d   = new_last;
      h_short_d  = new_short;
      beat_cnt_d = new_last ? '0 : beat_cnt_q + CW'(1);
    end else if (move) begin
      h_valid_d = 1'b0;
      h_last_d  = 1'b0;
      h_short_d = 1'b0;
    end else if (seal) begin
      h_last_d   = 1'b1;
      h_short_d  = 1'b1;
      beat_cnt_d = '0;
    end

    // idle time only matters while a packet is open and waiting
    if (h_open && !accept && !seal && (TIMEOUT != 0))
      idle_cnt_d = idle_cnt_q + IW'(1);
    else
      idle_cnt_d = '0;

    if (move) begin
      o_valid_d = 1'b1;
      o_data_d  = h_data_q;
      o_keep_d  = h_keep_q;
      o_last_d  = h_last_q;
      o_short_d = h_short_q;
    end else if (M_AXIS_TREADY) begin
      o_valid_d = 1'b0;
    end

    if (m_hs && o_last_q) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
      if (o_short_q)
        short_cnt_d = short_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      h_valid_q   <= 1'b0;
      h_data_q    <= '0;
      h_keep_q    <= '0;
      h_last_q    <= 1'b0;
      h_short_q   <= 1'b0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
      o_keep_q    <= '0;
      o_last_q    <= 1'b0;
      o_short_q   <= 1'b0;
      beat_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      short_cnt_q <= '0;
    end else begin
      h_valid_q   <= h_valid_d;
      h_data_q    <= h_data_d;
      h_keep_q    <= h_keep_d;
      h_last_q    <= h_last_d;
      h_short_q   <= h_short_d;
      o_valid_q   <= o_valid_d;
      o_data_q    <= o_data_d;
      o_keep_q    <= o_keep_d;
      o_last_q    <= o_last_d;
      o_short_q   <= o_short_d;
      beat_cnt_q  <= beat_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      short_cnt_q <= short_cnt_d;
    end
  end

  assign S_AXIS_TREADY   = s_ready;
  assign M_AXIS_TDATA    = o_data_q;
  assign M_AXIS_TKEEP    = o_keep_q;
  assign M_AXIS_TLAST    = o_last_q;
  assign M_AXIS_TVALID   = o_valid_q;
  assign pkt_count       = pkt_cnt_q;
  assign short_pkt_count = short_cnt_q;

endmodule

// File: doc/axis_packetizer.md
# axis_packetizer

Frames a raw, unterminated AXI4-Stream of fixed-width beats into packets by generating TLAST, and feeds the downstream AXIS FIFO wrapper's slave port. Packets close after PKT_LEN beats, or earlier on an idle timeout or an explicit flush, so no partial packet is stranded when the source goes quiet. The block holds one beat back so TLAST can be attached after the fact, and keeps packet statistics for software.

## Interface
- TDATA_WIDTH, 128: data width in bits, multiple of 8.
- PKT_LEN, 16: beats per full packet, ≥1.
- TIMEOUT, 1024: idle cycles before an open packet is closed; 0 disables timeout.

- aclk  in  1  single clock, all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- S_AXIS_TDATA  in  TDATA_WIDTH  input payload.
- S_AXIS_TKEEP  in  TDATA_WIDTH/8  input byte qualifier, carried through unchanged.
- S_AXIS_TVALID  in  1  input valid.
- S_AXIS_TREADY  out  1  input ready.
- flush  in  1  level, close current packet at the earliest opportunity.
- M_AXIS_TDATA  out  TDATA_WIDTH  output payload.
- M_AXIS_TKEEP  out  TDATA_WIDTH/8  output byte qualifier.
- M_AXIS_TLAST  out  1  packet boundary.
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TREADY  in  1  output ready.
- pkt_count  out  32  packets delivered on M_AXIS, wraps at 2^32.
- short_pkt_count  out  32  delivered packets closed by timeout or flush with fewer than PKT_LEN beats, wraps.

## Operation
- Two registers:
  - Hold H: h_valid, h_data, h_keep, h_last.
  - Output O: drives M_AXIS_*.
  - o_free = !M_AXIS_TVALID || M_AXIS_TREADY.
- S_AXIS_TREADY = aresetn && (!h_valid || o_free). Accept = S_AXIS_TVALID && S_AXIS_TREADY.
- Move H→O when o_free && h_valid && (h_last || accept). O gets h_data/h_keep and TLAST = h_last.
  - If nothing moves and M_AXIS_TREADY is high, M_AXIS_TVALID clears.
- On accept, the new beat enters H (same edge as any move).
  - h_last = (beat_cnt == PKT_LEN-1) || flush.
- beat_cnt, width $clog2(PKT_LEN)+1:
  - +1 on accept.
  - Set to 0 when the accepted beat gets h_last=1, or when H is sealed by timeout/flush.
- Sealing an open H (h_valid && !h_last && !accept):
  - flush high, or idle_cnt reaching TIMEOUT: set h_last=1 and mark H short. beat_cnt <= 0.
  - The move to O occurs on a following edge.
- idle_cnt:
  - +1 each cycle H is open and no accept occurs. Counts whether or not O is stalled.
  - Cleared on accept, when H empties, or on seal.
  - Seal fires on the edge where idle_cnt == TIMEOUT-1 and no accept occurs, i.e. after TIMEOUT idle cycles.
- A "short" flag travels H→O with the beat. It is set for a seal by timeout or flush, and for an accepted beat made last by flush when beat_cnt < PKT_LEN-1.
- On an M_AXIS handshake with TLAST=1: pkt_count +1. If the beat is also short: short_pkt_count +1.
- flush with H empty and no accept: ignored. Empty packets are never produced.
- Simultaneous events:
  - accept + timeout expiry: accept wins. Old H leaves with TLAST=0.
  - accept + flush: the new beat is last, the old H beat leaves with TLAST=0.
- Reset (any time, asynchronous): all beats in H and O are discarded; counters and state go to 0.

## Timing
- Reset values:
  - M_AXIS_TVALID, M_AXIS_TLAST: 0.
  - M_AXIS_TDATA, M_AXIS_TKEEP: 0.
  - pkt_count, short_pkt_count: 0.
  - S_AXIS_TREADY: 0 during reset, 1 in the first cycle after deassertion.
- Latency:
  - A beat with h_last=1 accepted at edge N appears on M_AXIS after edge N+1 when O is free.
  - A non-last beat leaves on the edge that accepts its successor.
  - A beat sealed by timeout appears TIMEOUT+1 edges after its last-accept edge, assuming M ready.
- Throughput: 1 beat/cycle sustained with M_AXIS_TREADY high, including across packet boundaries.
- AXIS rules: M_AXIS_TDATA/TKEEP/TLAST are stable while TVALID && !TREADY. TVALID never depends combinationally on TREADY.

## Test plan
- Continuous 48 beats, data = index, keep all-ones, M ready = 1, PKT_LEN=16 → 3 packets; TLAST on beats 15, 31, 47; pkt_count=3, short_pkt_count=0; no bubbles after first output.
- 5 beats then S_AXIS_TVALID low, TIMEOUT=8 → beat 4 emerges with TLAST=1 9 edges after its accept; pkt_count=1, short_pkt_count=1; next beat starts a new packet with beat_cnt=0.
- 3 beats, flush pulsed one cycle with the 3rd accept → beat 2 TLAST=1, short_pkt_count=1. Flush pulsed with H empty → no output, counters unchanged.
- Random M_AXIS_TREADY (50%) over 160 beats, PKT_LEN=16 → data order preserved, 10 packets, output stable under stall, TREADY low whenever H is full and O stalled.
- aresetn asserted mid-packet with H and O full → M_AXIS_TVALID=0 immediately, counters 0. After release, a 16-beat burst yields one clean packet, TLAST on beat 15.
- TIMEOUT=0 with 5 beats then idle for 2000 cycles → beat 4 held, never output, until the 6th beat or a flush.
